// File: rtl/acfa_cflow_logger_pkg.sv
// Shared definitions for the ACFA control-flow logger.
// State encodings, default log geometry and pointer step.
package acfa_cflow_logger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOG  = 2'd1,
    ST_FULL = 2'd2
  } log_state_e;

  localparam logic [15:0] CFLOW_LOGS_SIZE = 16'h0100;
  localparam logic [15:0] CFLOW_PTR_STEP  = 16'd2;

endpackage

// File: rtl/acfa_cflow_logger_xfer_detect.sv
// Classifies a retired instruction as a non-sequential
// transfer originating inside the executable region.
module acfa_xfer_detect
  import acfa_cflow_logger_pkg::*;
(
  input  logic        ev_valid,
  input  logic [15:0] ev_src,
  input  logic [15:0] ev_dest,
  input  logic [2:0]  ev_len,
  input  logic [15:0] er_min,
  input  logic [15:0] er_max,
  output logic        xfer
);

  logic [15:0] seq_addr;
  logic        in_er;
  logic        non_seq;

  // 16-bit sum wraps on purpose
  assign seq_addr = ev_src + {13'd0, ev_len};
  assign non_seq  = (ev_dest != seq_addr);
  assign in_er    = (ev_src >= er_min) && (ev_src <= er_max);
  assign xfer     = ev_valid && non_seq && in_er;

endmodule

// File: rtl/acfa_cflow_logger.sv
// Control-flow logger: detects region-local jumps and
// streams {src, dest} pairs into the CF-log memory.
module acfa_cflow_logger
  import acfa_cflow_logger_pkg::*;
#(
  parameter logic [15:0] LOG_WORDS = CFLOW_LOGS_SIZE,
  parameter logic [15:0] PTR_STEP  = CFLOW_PTR_STEP
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        ev_valid,
  input  logic [15:0] ev_src,
  input  logic [15:0] ev_dest,
  input  logic [2:0]  ev_len,
  input  logic [15:0] ER_min,
  input  logic [15:0] ER_max,
  input  logic        log_en,
  input  logic        log_clr,
  output logic [15:0] cflow_logs_ptr_din,
  output logic [15:0] cflow_src,
  output logic [15:0] cflow_dest,
  output logic        cflow_hw_wen,
  output logic        log_full,
  output logic        full_pulse,
  output logic        log_ovf
);

  log_state_e  state;
  logic        xfer;
  logic [15:0] ptr_nxt;

  acfa_xfer_detect u_detect (
    .ev_valid (ev_valid),
    .ev_src   (ev_src),
    .ev_dest  (ev_dest),
    .ev_len   (ev_len),
    .er_min   (ER_min),
    .er_max   (ER_max),
    .xfer     (xfer)
  );

  assign ptr_nxt = cflow_logs_ptr_din + PTR_STEP;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state              <= ST_IDLE;
      cflow_logs_ptr_din <= '0;
      cflow_src          <= '0;
      cflow_dest         <= '0;
      cflow_hw_wen       <= 1'b0;
      log_full           <= 1'b0;
      full_pulse         <= 1'b0;
      log_ovf            <= 1'b0;
    end else begin
      cflow_hw_wen <= 1'b0;
      full_pulse   <= 1'b0;
      // clear beats any same-cycle transfer
      if (log_clr) begin
        cflow_logs_ptr_din <= '0;
        log_full           <= 1'b0;
        log_ovf            <= 1'b0;
        state <= log_en ? ST_LOG : ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (log_en) state <= ST_LOG;
          end
          ST_LOG: begin
            if (xfer) begin
              cflow_src          <= ev_src;
              cflow_dest         <= ev_dest;
              cflow_logs_ptr_din <= ptr_nxt;
              cflow_hw_wen       <= 1'b1;
              if (ptr_nxt == LOG_WORDS) begin
                state      <= ST_FULL;
                log_full   <= 1'b1;
                full_pulse <= 1'b1;
              end else if (!log_en) begin
                state <= ST_IDLE;
              end
            end else if (!log_en) begin
              state <= ST_IDLE;
            end
          end
          ST_FULL: begin
            if (xfer) log_ovf <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acfa_cflow_logger.sv
// Directed bench for acfa_cflow_logger with an 8-word log.
// Expected values are hand-derived per step.
module tb_acfa_cflow_logger;
  import acfa_cflow_logger_pkg::*;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        ev_valid;
  logic [15:0] ev_src;
  logic [15:0] ev_dest;
  logic [2:0]  ev_len;
  logic [15:0] ER_min;
  logic [15:0] ER_max;
  logic        log_en;
  logic        log_clr;
  logic [15:0] cflow_logs_ptr_din;
  logic [15:0] cflow_src;
  logic [15:0] cflow_dest;
  logic        cflow_hw_wen;
  logic        log_full;
  logic        full_pulse;
  logic        log_ovf;

  int tests  = 0;
  int failed = 0;

  acfa_cflow_logger #(
    .LOG_WORDS (16'd8),
    .PTR_STEP  (16'd2)
  ) dut (
    .mclk               (mclk),
    .puc_rst            (puc_rst),
    .ev_valid           (ev_valid),
    .ev_src             (ev_src),
    .ev_dest            (ev_dest),
    .ev_len             (ev_len),
    .ER_min             (ER_min),
    .ER_max             (ER_max),
    .log_en             (log_en),
    .log_clr            (log_clr),
    .cflow_logs_ptr_din (cflow_logs_ptr_din),
    .cflow_src          (cflow_src),
    .cflow_dest         (cflow_dest),
    .cflow_hw_wen       (cflow_hw_wen),
    .log_full           (log_full),
    .full_pulse         (full_pulse),
    .log_ovf            (log_ovf)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic ev(input logic [15:0] s,
                    input logic [15:0] d,
                    input logic [2:0]  l);
    ev_valid = 1'b1;
    ev_src   = s;
    ev_dest  = d;
    ev_len   = l;
  endtask

  task automatic chk_wr(input string tag,
                        input logic        wen,
                        input logic [15:0] ptr);
    chk({tag, "_wen"}, 32'(cflow_hw_wen), 32'(wen));
    chk({tag, "_ptr"}, 32'(cflow_logs_ptr_din), 32'(ptr));
  endtask

  initial begin
    puc_rst  = 1'b1;
    ev_valid = 1'b0;
    ev_src   = '0;
    ev_dest  = '0;
    ev_len   = 3'd2;
    ER_min   = 16'hE000;
    ER_max   = 16'hE0FF;
    log_en   = 1'b0;
    log_clr  = 1'b0;
    #1;
    chk("rst_ptr", 32'(cflow_logs_ptr_din), 32'd0);
    chk("rst_src", 32'(cflow_src), 32'd0);
    chk("rst_dest", 32'(cflow_dest), 32'd0);
    chk("rst_wen", 32'(cflow_hw_wen), 32'd0);
    chk("rst_full", 32'(log_full), 32'd0);
    chk("rst_pulse", 32'(full_pulse), 32'd0);
    chk("rst_ovf", 32'(log_ovf), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    tick();
    tick();
    puc_rst = 1'b0;
    tick();

    // IDLE -> LOG; jump in this cycle is ignored
    log_en = 1'b1;
    ev(16'hE010, 16'hE080, 3'd4);
    tick();
    chk("idle_drop_wen", 32'(cflow_hw_wen), 32'd0);
    chk("en_state", 32'(dut.state), 32'(ST_LOG));

    // T1 sequential run
    for (int i = 0; i < 10; i++) begin
      ev(16'hE000 + 16'(2 * i), 16'hE002 + 16'(2 * i), 3'd2);
      tick();
      chk_wr("t1", 1'b0, 16'd0);
    end

    // T2 single jump
    ev(16'hE010, 16'hE080, 3'd4);
    tick();
    chk_wr("t2", 1'b1, 16'd2);
    chk("t2_src", 32'(cflow_src), 32'hE010);
    chk("t2_dest", 32'(cflow_dest), 32'hE080);
    ev_valid = 1'b0;
    tick();
    chk_wr("t2_after", 1'b0, 16'd2);
    chk("t2_hold_src", 32'(cflow_src), 32'hE010);

    // T3 out of region, then upper boundary
    ev(16'hD000, 16'h1234, 3'd2);
    tick();
    chk_wr("t3_out", 1'b0, 16'd2);
    chk("t3_out_src", 32'(cflow_src), 32'hE010);
    ev(16'hE0FF, 16'hE000, 3'd2);
    tick();
    chk_wr("t3_bnd", 1'b1, 16'd4);
    chk("t3_bnd_src", 32'(cflow_src), 32'hE0FF);

    // wrap: FFFE + 2 == 0000 is sequential
    ER_max = 16'hFFFF;
    ev(16'hFFFE, 16'h0000, 3'd2);
    tick();
    chk_wr("wrap_seq", 1'b0, 16'd4);
    ER_max = 16'hE0FF;

    // clear in LOG keeps LOG
    ev_valid = 1'b0;
    log_clr  = 1'b1;
    tick();
    log_clr = 1'b0;
    chk_wr("clr", 1'b0, 16'd0);
    chk("clr_state", 32'(dut.state), 32'(ST_LOG));

    // T4 fill an 8-word log
    for (int i = 0; i < 4; i++) begin
      ev(16'hE020 + 16'(16 * i), 16'hE000, 3'd2);
      tick();
      chk_wr("t4_fill", 1'b1, 16'(2 * (i + 1)));
      chk("t4_full", 32'(log_full), 32'(i == 3));
      chk("t4_pulse", 32'(full_pulse), 32'(i == 3));
    end
    chk("t4_state", 32'(dut.state), 32'(ST_FULL));
    ev(16'hE060, 16'hE000, 3'd2);
    tick();
    chk_wr("t4_5th", 1'b0, 16'd8);
    chk("t4_ovf", 32'(log_ovf), 32'd1);
    chk("t4_pulse_off", 32'(full_pulse), 32'd0);
    chk("t4_full_hold", 32'(log_full), 32'd1);
    chk("t4_src_hold", 32'(cflow_src), 32'hE050);

    // T5 clear races a jump while FULL
    ev(16'hE070, 16'hE000, 3'd2);
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
    chk_wr("t5", 1'b0, 16'd0);
    chk("t5_full", 32'(log_full), 32'd0);
    chk("t5_ovf", 32'(log_ovf), 32'd0);
    chk("t5_state", 32'(dut.state), 32'(ST_LOG));

    // log_en falls with a jump: still logged, then IDLE
    log_en = 1'b0;
    ev(16'hE030, 16'hE0A0, 3'd6);
    tick();
    chk_wr("en_fall", 1'b1, 16'd2);
    chk("en_fall_state", 32'(dut.state), 32'(ST_IDLE));
    ev(16'hE040, 16'hE0B0, 3'd2);
    tick();
    chk_wr("idle_jump", 1'b0, 16'd2);
    chk("idle_ovf", 32'(log_ovf), 32'd0);

    // T6 reset mid-stream at ptr=6
    log_en   = 1'b1;
    ev_valid = 1'b0;
    tick();
    ev(16'hE044, 16'hE000, 3'd2);
    tick();
    chk_wr("t6_pre4", 1'b1, 16'd4);
    tick();
    chk_wr("t6_pre6", 1'b1, 16'd6);
    #2;
    puc_rst = 1'b1;
    #1;
    chk_wr("t6_rst", 1'b0, 16'd0);
    chk("t6_rst_src", 32'(cflow_src), 32'd0);
    chk("t6_rst_dest", 32'(cflow_dest), 32'd0);
    chk("t6_rst_state", 32'(dut.state), 32'(ST_IDLE));
    ev_valid = 1'b0;
    tick();
    puc_rst = 1'b0;
    tick();
    chk("t6_state_log", 32'(dut.state), 32'(ST_LOG));
    ev(16'hE010, 16'hE080, 3'd4);
    tick();
    chk_wr("t6_post", 1'b1, 16'd2);
    ev_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
